// File: rtl/led_matrix_scan_ctrl_if.sv
// rtl/led_matrix_scan_ctrl_if.sv - frame-buffer read port and 74HC595 chain pins
interface led_matrix_scan_ctrl_if #(
  parameter int ROWS     = 8,
  parameter int COL_BITS = 24
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [COL_BITS-1:0] rd_data;
  logic                ds;
  logic                shcp;
  logic                stcp;
  logic                oe;

  modport master (
    output rd_en, rd_addr, ds, shcp, stcp, oe,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, ds, shcp, stcp, oe,
    output rd_data
  );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// rtl/led_matrix_scan_ctrl.sv - row-scan FSM: fetch, shift, latch, dwell per matrix row
module led_matrix_scan_ctrl #(
  parameter int CLK_DIV  = 128,
  parameter int ROWS     = 8,
  parameter int COL_BITS = 24,
  parameter int DWELL    = 380
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   frame_done,
  output logic                   busy,
  led_matrix_scan_ctrl_if.master bus
);
  localparam int W     = COL_BITS + ROWS;
  localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(W + 1);
  localparam int DW_W  = $clog2(DWELL + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             fetch_second;
  logic [BIT_W-1:0] bit_cnt;
  logic [DW_W-1:0]  dwell_cnt;
  logic [W-1:0]     word;
  logic [ROWS-1:0]  row_sel;
  logic [AW-1:0]    rd_addr_q;
  logic             rd_en_q;
  logic             shcp_q;
  logic             stcp_q;
  logic             oe_q;

  assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign row_sel = ~(ROWS'(1) << rd_addr_q);
  assign busy    = (state != IDLE);

  // ds is the live MSB of the shift word, so it only moves when the word moves
  assign bus.ds      = word[W-1];
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.shcp    = shcp_q;
  assign bus.stcp    = stcp_q;
  assign bus.oe      = oe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      fetch_second <= 1'b0;
      bit_cnt      <= '0;
      dwell_cnt    <= '0;
      word         <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      shcp_q       <= 1'b0;
      stcp_q       <= 1'b0;
      oe_q         <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      frame_done <= 1'b0;
      div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (enable) begin
            state        <= FETCH;
            rd_en_q      <= 1'b1;
            fetch_second <= 1'b0;
          end
        end
        FETCH: begin
          div_cnt <= '0;
          if (!fetch_second) begin
            fetch_second <= 1'b1;
          end else begin
            word    <= {row_sel, bus.rd_data};
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!shcp_q) begin
              shcp_q <= 1'b1;
            end else begin
              shcp_q  <= 1'b0;
              word    <= {word[W-2:0], 1'b0};
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (bit_cnt == BIT_W'(W - 1)) begin
                state  <= LATCH;
                stcp_q <= 1'b1;
              end
            end
          end
        end
        LATCH: begin
          if (tick) begin
            stcp_q    <= 1'b0;
            oe_q      <= 1'b0;
            dwell_cnt <= '0;
            state     <= DISPLAY;
          end
        end
        DISPLAY: begin
          if (tick) begin
            if (dwell_cnt == DW_W'(DWELL - 1)) begin
              oe_q       <= 1'b1;
              rd_addr_q  <= (rd_addr_q == AW'(ROWS - 1)) ? '0 : rd_addr_q + AW'(1);
              frame_done <= (rd_addr_q == AW'(ROWS - 1));
              if (enable) begin
                state        <= FETCH;
                rd_en_q      <= 1'b1;
                fetch_second <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DW_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// tb/tb_led_matrix_scan_ctrl.sv - directed bench for led_matrix_scan_ctrl (CLK_DIV=2, DWELL=4)
module tb_led_matrix_scan_ctrl;
  logic clk;
  logic reset;
  logic enable;
  logic frame_done;
  logic busy;

  led_matrix_scan_ctrl_if #(.ROWS(8), .COL_BITS(24)) bus ();

  led_matrix_scan_ctrl #(.CLK_DIV(2), .ROWS(8), .COL_BITS(24), .DWELL(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_done (frame_done),
    .busy       (busy),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] fb_row(input int r);
    case (r)
      0: fb_row = 24'hA5C3F0;
      1: fb_row = 24'h123456;
      2: fb_row = 24'hFFFFFF;
      3: fb_row = 24'h000000;
      4: fb_row = 24'h800001;
      5: fb_row = 24'h5A5A5A;
      6: fb_row = 24'hC0FFEE;
      default: fb_row = 24'h0F0F0F;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int r);
    logic [7:0] sel;
    sel = 8'h01 << r;
    exp_word = {~sel, fb_row(r)};
  endfunction

  always @(posedge clk) if (bus.rd_en) bus.rd_data <= fb_row(int'(bus.rd_addr));

  int checks = 0;
  int failures = 0;
  int rises, stcp_pulses, stcp_cyc, oe_low, rd_en_cnt, fd_cnt, rises_at_stcp, total, n, snap;
  logic [31:0] cap;
  logic [2:0] addr_seen;
  logic prev_shcp = 1'b0, prev_stcp = 1'b0, prev_ds = 1'b0, prev_oe = 1'b1;
  logic rd_en_p1 = 1'b0, rd_en_p2 = 1'b0, rst_edge;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample #1 after the edge, update counters, check the pin invariants
  task automatic step();
    logic ok;
    rst_edge = reset;
    @(posedge clk);
    #1;
    if (!prev_shcp && bus.shcp) begin
      if (rises == 0) addr_seen = bus.rd_addr;
      cap = {cap[30:0], bus.ds};
      rises++;
    end
    if (bus.stcp) begin
      stcp_cyc++;
      if (!prev_stcp) begin
        stcp_pulses++;
        rises_at_stcp = rises;
      end
    end
    if (!bus.oe) oe_low++;
    if (bus.rd_en) rd_en_cnt++;
    if (frame_done) fd_cnt++;
    ok = 1'b1;
    if (!bus.oe && (bus.stcp || bus.rd_en || !busy || bus.shcp !== prev_shcp)) ok = 1'b0;
    if (bus.ds !== prev_ds && !((prev_shcp && !bus.shcp) || rd_en_p2 || rst_edge)) ok = 1'b0;
    if (frame_done && !bus.oe) ok = 1'b0;
    chk("pin_invariant", {63'd0, ok}, 64'd1);
    rd_en_p2  = rd_en_p1;
    rd_en_p1  = bus.rd_en;
    prev_shcp = bus.shcp;
    prev_stcp = bus.stcp;
    prev_ds   = bus.ds;
    prev_oe   = bus.oe;
  endtask

  task automatic run_row(input int r, input int drop_at, output int clocks);
    logic seen_low, done;
    int c;
    rises = 0; stcp_pulses = 0; stcp_cyc = 0; oe_low = 0; cap = '0;
    rises_at_stcp = -1; seen_low = 1'b0; done = 1'b0; c = 0;
    while (!done && c < 400) begin
      if (c == drop_at) enable = 1'b0;
      step();
      c++;
      if (!bus.oe) seen_low = 1'b1;
      else if (seen_low) done = 1'b1;
    end
    clocks = c;
    chk("row_completes", {63'd0, done}, 64'd1);
    chk("row_word", {32'd0, cap}, {32'd0, exp_word(r)});
    chk("shcp_rises", rises, 32);
    chk("row_addr", {61'd0, addr_seen}, r);
    chk("stcp_pulses", stcp_pulses, 1);
    chk("stcp_width", stcp_cyc, 2);
    chk("stcp_after_last_rise", rises_at_stcp, 32);
    chk("dwell_clocks", oe_low, 8);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rd_en_cnt = 0; fd_cnt = 0; rises = 0; cap = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (50) step();
    chk("idle_rd_en", {63'd0, bus.rd_en}, 0);
    chk("idle_rd_addr", {61'd0, bus.rd_addr}, 0);
    chk("idle_ds", {63'd0, bus.ds}, 0);
    chk("idle_shcp", {63'd0, bus.shcp}, 0);
    chk("idle_stcp", {63'd0, bus.stcp}, 0);
    chk("idle_oe", {63'd0, bus.oe}, 1);
    chk("idle_frame_done", {63'd0, frame_done}, 0);
    chk("idle_busy", {63'd0, busy}, 0);
    chk("idle_no_fetch", rd_en_cnt, 0);

    enable = 1'b1;
    run_row(0, -1, n);
    chk("row0_clocks", n, 141);
    chk("row0_next_addr", {61'd0, bus.rd_addr}, 1);
    total = n;
    for (int r = 1; r < 8; r++) begin
      run_row(r, -1, n);
      chk("row_clocks", n, 140);
      total += n;
    end
    chk("frame_done_at_wrap", {63'd0, frame_done}, 1);
    chk("frame_done_count", fd_cnt, 1);
    chk("addr_wrap", {61'd0, bus.rd_addr}, 0);
    chk("frame_clocks", total, 1121);

    for (int r = 0; r < 3; r++) begin
      run_row(r, -1, n);
      chk("frame2_row_clocks", n, 140);
    end
    chk("frame_done_single", fd_cnt, 1);
    run_row(3, 20, n);
    chk("stop_row_clocks", n, 140);
    chk("stop_busy", {63'd0, busy}, 0);
    chk("stop_oe", {63'd0, bus.oe}, 1);
    chk("stop_addr", {61'd0, bus.rd_addr}, 4);
    snap = rd_en_cnt;
    repeat (20) step();
    chk("stopped_no_fetch", rd_en_cnt, snap);
    chk("stopped_busy", {63'd0, busy}, 0);
    enable = 1'b1;
    run_row(4, -1, n);
    chk("resume_clocks", n, 141);

    repeat (30) step();
    chk("mid_shift_busy", {63'd0, busy}, 1);
    reset = 1'b1; enable = 1'b0;
    step();
    chk("abort_shcp", {63'd0, bus.shcp}, 0);
    chk("abort_stcp", {63'd0, bus.stcp}, 0);
    chk("abort_oe", {63'd0, bus.oe}, 1);
    chk("abort_addr", {61'd0, bus.rd_addr}, 0);
    chk("abort_busy", {63'd0, busy}, 0);
    chk("abort_rd_en", {63'd0, bus.rd_en}, 0);
    reset = 1'b0;
    stcp_pulses = 0;
    repeat (200) step();
    chk("abort_no_stcp", stcp_pulses, 0);
    chk("abort_idle_busy", {63'd0, busy}, 0);
    chk("abort_idle_oe", {63'd0, bus.oe}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
